// File: rtl/neuron_mac.sv
// neuron_mac: single-neuron multiply-accumulate with bias, saturation and activation for the ELM hidden layer.
// Define RELU_EN to select ReLU activation; otherwise the saturated result passes through unchanged.
module neuron_mac #(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [dataWidth-1:0] myinput,
    input  logic                        myinputValid,
    input  logic signed [dataWidth-1:0] bias,
    output logic                        weight_ren,
    output logic [addressWidth:0]       weight_raddr,
    input  logic signed [dataWidth-1:0] weight_rdata,
    output logic signed [dataWidth-1:0] out,
    output logic                        outvalid
);
    localparam int PW = 2 * dataWidth;
    localparam int AW = 2 * dataWidth + addressWidth + 1;
    localparam logic [addressWidth:0] LAST = (addressWidth + 1)'(numWeight - 1);
    localparam logic [addressWidth:0] ONE  = (addressWidth + 1)'(1);
    localparam logic signed [AW-1:0] SMAX = {{(AW - dataWidth + 1){1'b0}}, {(dataWidth - 1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    typedef enum logic {ACCUM, FINISH} state_t;

    state_t                      state, state_nxt;
    logic signed [dataWidth-1:0] x_d;
    logic                        v1, v2;
    logic signed [PW-1:0]        prod;
    logic signed [AW-1:0]        acc, prod_x, bias_x, sum, r;
    logic [addressWidth:0]       tcnt;
    logic                        done, fin;
    logic signed [dataWidth-1:0] sat, act;

    assign weight_ren = myinputValid;
    assign prod_x     = {{(AW - PW){prod[PW-1]}}, prod};
    assign bias_x     = {{(AW - dataWidth){bias[dataWidth-1]}}, bias};
    assign done       = v2 && tcnt == LAST;

    always_comb begin
        fin       = state == FINISH;
        state_nxt = fin ? ACCUM : (done ? FINISH : ACCUM);
        sum       = acc + (bias_x <<< fracBits);
        r         = sum >>> fracBits;
        sat       = r > SMAX ? SMAX[dataWidth-1:0] : (r < SMIN ? SMIN[dataWidth-1:0] : r[dataWidth-1:0]);
`ifdef RELU_EN
        act       = sat[dataWidth-1] ? '0 : sat;
`else
        act       = sat;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACCUM;
            weight_raddr <= '0;
            x_d          <= '0;
            v1           <= 1'b0;
            prod         <= '0;
            v2           <= 1'b0;
            acc          <= '0;
            tcnt         <= '0;
            out          <= '0;
            outvalid     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (myinputValid) begin
                weight_raddr <= weight_raddr == LAST ? '0 : weight_raddr + ONE;
                x_d          <= myinput;
            end
            v1   <= myinputValid;
            prod <= PW'(x_d) * PW'(weight_rdata);
            v2   <= v1;
            // FINISH restarts the accumulator with any term already in flight
            if (fin)
                acc <= v2 ? prod_x : '0;
            else if (v2)
                acc <= acc + prod_x;
            if (v2)
                tcnt <= done ? '0 : tcnt + ONE;
            outvalid <= fin;
            if (fin)
                out <= act;
        end
    end
endmodule

// File: doc/neuron_mac.md
# neuron_mac

Single-neuron multiply-accumulate stage of the ELM hidden layer. It sits directly downstream of a per-neuron weight memory: it issues read enables and addresses, consumes the one-cycle-latency weight word, and multiplies it against the streamed input feature. After `numWeight` terms it adds the neuron bias, applies the activation and saturation, and presents one fixed-point result with a one-cycle valid pulse to the layer output collector.

## Interface
- `numWeight`, 784: terms per input vector; must be ≤ 2**addressWidth.
- `addressWidth`, 10: weight memory depth exponent. Address port width is addressWidth+1.
- `dataWidth`, 16: signed two's-complement width of inputs, weights, bias and output.
- `fracBits`, 8: fractional bits of the shared Q format.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `myinput`  in  dataWidth  input feature, signed.
- `myinputValid`  in  1  `myinput` is valid this cycle. Gaps are allowed and there is no backpressure.
- `bias`  in  dataWidth  signed neuron bias. It is sampled only in the FINISH cycle.
- `weight_ren`  out  1  read enable to the weight memory.
- `weight_raddr`  out  addressWidth+1  weight read address.
- `weight_rdata`  in  dataWidth  weight word, valid the cycle after `weight_ren`.
- `out`  out  dataWidth  signed neuron result.
- `outvalid`  out  1  one-cycle pulse when `out` is updated.

## Operation
- `weight_ren` = `myinputValid`, combinationally.
- `weight_raddr` is a registered counter, reset 0. It increments on each valid input. On the input that reads address numWeight-1 it wraps to 0.
- Stage 1, end of cycle T with a valid input: `x_d <= myinput`, `v1 <= 1`.
- During T+1 `weight_rdata` is valid. At the end of T+1: `prod <= x_d * weight_rdata` (signed, 2*dataWidth bits), `v2 <= v1`.
- At the end of T+2, if `v2`: `acc <= acc + sext(prod)`. `acc` is 2*dataWidth+addressWidth+1 bits, reset 0, and never saturates internally.
- A term counter `tcnt` (reset 0) increments per accumulated term. When the term that makes `tcnt` = numWeight is accumulated, the counter clears and FINISH is flagged for the next cycle.
- FINISH (one cycle):
  - `sum = acc + (sext(bias) << fracBits)`.
  - `r = sum >>> fracBits` (arithmetic shift).
  - Saturate `r` to [-2**(dataWidth-1), 2**(dataWidth-1)-1].
  - Apply the activation.
  - Register the result into `out` and pulse `outvalid`.
- In FINISH, `acc <= v2 ? sext(prod) : 0`. A back-to-back next vector therefore loses no term.
- FSM is two states:
  - ACCUM → FINISH on completing the final term.
  - FINISH → ACCUM unconditionally.
- Inputs are accepted in every state, including FINISH.

## Timing
- Reset values: `weight_raddr`=0, `out`=0, `outvalid`=0. `x_d`, `v1`, `prod`, `v2`, `acc` and `tcnt` are all 0, and the state is ACCUM. `weight_ren` follows `myinputValid`, which is ignored while `rst_n`=0.
- Latency: last valid input in cycle T → `outvalid`=1 during T+4.
- Throughput: one term per cycle sustained. One result per numWeight valid inputs; results can be as little as numWeight cycles apart.
- `outvalid` is exactly one cycle wide. `out` holds its value until the next FINISH.
- Reset asserted mid-vector: all partial state is discarded. After release, the next valid input is term 0 at address 0, and no `outvalid` appears for the aborted vector.
- A `myinputValid` that is not contiguous has no effect on results: each term is tagged by its own v1/v2.

## Configuration
- `RELU_EN` defined: activation is ReLU, so a negative saturated result yields `out`=0.
- `RELU_EN` undefined: activation is identity, so `out` is the saturated signed result.
- Saturation is always present.

## Test plan
- numWeight=4, fracBits=8, inputs 256,256,256,256 contiguous, all weights 256, bias 0 → `out`=1024 with `outvalid` 4 cycles after the 4th input. Addresses issued are 0,1,2,3, then 0.
- Same vector with weights -512 and bias 0 → `out`=0 with `RELU_EN`; `out`=16'hF800 (-2048) without it.
- Inputs 32767 ×4, weights 32767, bias 32767 → `out`=32767. With inputs -32768 and no `RELU_EN` → `out`=-32768.
- Inputs 256 ×4 with 1–3 idle cycles between them, weights 256, bias 512 (2.0) → `out`=1536, and exactly one `outvalid` pulse.
- Two vectors back-to-back with no gap: {256 ×4} then {512 ×4}, weights 256, bias 0 → `outvalid` pulses 4 cycles apart with `out`=1024 then 2048.
- Assert `rst_n` after 2 inputs, release, then send 4 inputs of 256 → a single `out`=1024, addresses restart at 0, and there is no spurious `outvalid`.
